wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) normally wins, and the
// long-latency unit (B) is forced through after STARVE_LIMIT lost arbitrations.
// Optional statistics counters are enabled by defining WB_PORT_ARB_STATS_EN.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_we,
    input  logic [2:0]  a_addr,
    input  logic [15:0] a_data,
    input  logic [1:0]  a_bp,
    input  logic        b_valid,
    input  logic [2:0]  b_addr,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        stall_pipe,
    output logic        rf_we,
    output logic [2:0]  rf_addr,
    output logic [15:0] rf_data,
    output logic [1:0]  rf_bp,
    output logic [15:0] conflict_cnt,
    output logic [15:0] force_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cnt_inc;
    logic        a_acc;
    logic        rf_we_q, rf_we_d;
    logic [2:0]  rf_addr_q, rf_addr_d;
    logic [15:0] rf_data_q, rf_data_d;
    logic [1:0]  rf_bp_q, rf_bp_d;
    logic        force_entry;

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_pipe = 1'b0;
        b_ready    = 1'b0;
        a_acc      = 1'b0;
        case (state_q)
            IDLE: begin
                b_ready = b_valid & ~a_we;
                a_acc   = a_we;
                if (a_we && b_valid) begin
                    cnt_d   = 4'd1;
                    state_d = (LIMIT == 4'd1) ? FORCE : WAIT;
                end
            end
            WAIT: begin
                b_ready = b_valid & ~a_we;
                a_acc   = a_we;
                if (!b_valid || !a_we) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == LIMIT) ? FORCE : WAIT;
                end
            end
            FORCE: begin
                stall_pipe = 1'b1;
                b_ready    = b_valid;
                state_d    = IDLE;
                cnt_d      = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // Nothing is granted while reset is held.
        if (!reset) begin
            stall_pipe = 1'b0;
            b_ready    = 1'b0;
            a_acc      = 1'b0;
        end
    end

    assign force_entry = (state_q != FORCE) && (state_d == FORCE);

    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        rf_bp_d   = rf_bp_q;
        if (a_acc) begin
            rf_we_d   = 1'b1;
            rf_addr_d = a_addr;
            rf_data_d = a_data;
            rf_bp_d   = a_bp;
        end else if (b_ready) begin
            rf_we_d   = 1'b1;
            rf_addr_d = b_addr;
            rf_data_d = b_data;
            rf_bp_d   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= 3'd0;
            rf_data_q <= 16'd0;
            rf_bp_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            rf_bp_q   <= rf_bp_d;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;
    assign rf_bp   = rf_bp_q;

`ifdef WB_PORT_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;
    logic [15:0] force_q, force_d;

    always_comb begin
        conflict_d = conflict_q;
        force_d    = force_q;
        if (a_we && b_valid && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
        if (force_entry && force_q != 16'hFFFF)        force_d    = force_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_q <= 16'd0;
            force_q    <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
            force_q    <= force_d;
        end
    end

    assign conflict_cnt = conflict_q;
    assign force_cnt    = force_q;
`else
    logic unused_force_entry;
    assign unused_force_entry = force_entry;
    assign conflict_cnt = 16'd0;
    assign force_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus queues expected register-file
// writes, a negedge monitor pops and compares them as rf_we appears.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_we, b_valid;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic [1:0]  a_bp;
    logic        b_ready, stall_pipe, rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_data;
    logic [1:0]  rf_bp;
    logic [15:0] conflict_cnt, force_cnt;

    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b1;
    logic [20:0] exp_q[$];
    logic stats_en;

    wb_port_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_bp(a_bp),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .stall_pipe(stall_pipe),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_bp(rf_bp),
        .conflict_cnt(conflict_cnt), .force_cnt(force_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Win codes: 0 none, 1 A, 2 B.
    task automatic cyc(input logic aw, input logic [2:0] aa, input logic [15:0] ad,
                       input logic [1:0] ab, input logic bv, input logic [2:0] ba,
                       input logic [15:0] bd, input logic exp_rdy, input logic exp_stall,
                       input int win, input string tag);
        a_we = aw; a_addr = aa; a_data = ad; a_bp = ab;
        b_valid = bv; b_addr = ba; b_data = bd;
        #2;
        check({tag, "_b_ready"}, 32'(b_ready), 32'(exp_rdy));
        check({tag, "_stall"}, 32'(stall_pipe), 32'(exp_stall));
        if (win == 1) exp_q.push_back({aa, ad, ab});
        if (win == 2) exp_q.push_back({ba, bd, 2'd0});
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {11'd0, rf_addr, rf_data, rf_bp}, 32'hFFFF_FFFF);
            end else begin
                automatic logic [20:0] e = exp_q.pop_front();
                check("rf_write", {11'd0, rf_addr, rf_data, rf_bp}, {11'd0, e});
            end
        end
    end

    initial begin
`ifdef WB_PORT_ARB_STATS_EN
        stats_en = 1'b1;
`else
        stats_en = 1'b0;
`endif
        reset = 1'b0;
        a_we = 0; a_addr = 0; a_data = 0; a_bp = 0;
        b_valid = 1; b_addr = 3'd4; b_data = 16'h5555;
        repeat (2) @(posedge clk);
        #1;
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_stall", 32'(stall_pipe), 32'd0);
        check("rst_rf", {rf_we, rf_addr, rf_data, rf_bp}, 32'd0);
        check("rst_stats", {conflict_cnt, force_cnt}, 32'd0);
        reset = 1'b1;

        cyc(1, 3'd3, 16'h1234, 2'd2, 0, 3'd0, 16'h0000, 0, 0, 1, "a_only");
        cyc(0, 3'd0, 16'h0000, 2'd0, 1, 3'd5, 16'hBEEF, 1, 0, 2, "b_only");
        cyc(0, 3'd1, 16'h9999, 2'd3, 0, 3'd2, 16'h7777, 0, 0, 0, "idle");
        check("hold_rf", {rf_we, rf_addr, rf_data, rf_bp}, {1'b0, 3'd5, 16'hBEEF, 2'd0});

        // Starvation: three A wins, then one forced B cycle.
        cyc(1, 3'd1, 16'h1111, 2'd1, 1, 3'd6, 16'hCAFE, 0, 0, 1, "starve1");
        cyc(1, 3'd2, 16'h2222, 2'd3, 1, 3'd6, 16'hCAFE, 0, 0, 1, "starve2");
        cyc(1, 3'd6, 16'h3333, 2'd0, 1, 3'd6, 16'hCAFE, 0, 0, 1, "starve3");
        cyc(1, 3'd7, 16'h4444, 2'd1, 1, 3'd6, 16'hCAFE, 1, 1, 2, "force");
        cyc(1, 3'd7, 16'h4444, 2'd1, 0, 3'd0, 16'h0000, 0, 0, 1, "after_force");
        check("force_cnt", 32'(force_cnt), stats_en ? 32'd1 : 32'd0);
        check("conflict_cnt", 32'(conflict_cnt), stats_en ? 32'd4 : 32'd0);

        // A drops while waiting: B goes immediately and the count restarts.
        cyc(1, 3'd0, 16'hA000, 2'd0, 1, 3'd2, 16'hB000, 0, 0, 1, "wait1");
        cyc(1, 3'd1, 16'hA001, 2'd1, 1, 3'd2, 16'hB000, 0, 0, 1, "wait2");
        cyc(0, 3'd0, 16'h0000, 2'd0, 1, 3'd2, 16'hB000, 1, 0, 2, "a_drop");
        cyc(1, 3'd3, 16'hA003, 2'd2, 1, 3'd4, 16'hB111, 0, 0, 1, "restart1");
        cyc(1, 3'd3, 16'hA004, 2'd2, 1, 3'd4, 16'hB111, 0, 0, 1, "restart2");
        cyc(1, 3'd3, 16'hA005, 2'd2, 1, 3'd4, 16'hB111, 0, 0, 1, "restart3");
        cyc(1, 3'd3, 16'hA006, 2'd2, 1, 3'd4, 16'hB111, 1, 1, 2, "restart_force");

        // Reset while waiting with cnt=2.
        cyc(1, 3'd5, 16'hC000, 2'd1, 1, 3'd1, 16'hD000, 0, 0, 1, "pre_rst1");
        cyc(1, 3'd5, 16'hC001, 2'd1, 1, 3'd1, 16'hD000, 0, 0, 1, "pre_rst2");
        reset = 1'b0;
        cyc(0, 3'd5, 16'hC002, 2'd1, 1, 3'd1, 16'hD000, 0, 0, 0, "in_rst");
        check("mid_rst_rf", {rf_we, rf_addr, rf_data, rf_bp}, 32'd0);
        check("mid_rst_stats", {conflict_cnt, force_cnt}, 32'd0);
        reset = 1'b1;
        cyc(1, 3'd2, 16'hE000, 2'd3, 1, 3'd1, 16'hD000, 0, 0, 1, "post_rst1");
        cyc(1, 3'd2, 16'hE001, 2'd3, 1, 3'd1, 16'hD000, 0, 0, 1, "post_rst2");
        cyc(1, 3'd2, 16'hE002, 2'd3, 1, 3'd1, 16'hD000, 0, 0, 1, "post_rst3");
        cyc(1, 3'd2, 16'hE003, 2'd3, 1, 3'd1, 16'hD000, 1, 1, 2, "post_rst_force");
        cyc(0, 3'd0, 16'h0000, 2'd0, 0, 3'd0, 16'h0000, 0, 0, 0, "drain");
        @(posedge clk); #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        // Long conflict run for counter saturation; writes are not tracked here.
        mon_en = 1'b0;
        a_we = 1'b1; b_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        check("conflict_sat", 32'(conflict_cnt), stats_en ? 32'h0000_FFFF : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
